// File: rtl/id_stage.sv
// Registered RV32I + CSR decode stage with valid/ready flow, jump flush and load-use interlock.
// Build option: define ID_RVM_EN to accept the RV32M (MUL..REMU) encodings as R-type.
module id_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RF_AW    = 5,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      inst_i,
    input  logic [XLEN-1:0]  inst_addr_i,
    output logic [RF_AW-1:0] reg1_raddr_o,
    output logic [RF_AW-1:0] reg2_raddr_o,
    input  logic [XLEN-1:0]  reg1_rdata_i,
    input  logic [XLEN-1:0]  reg2_rdata_i,
    output logic [11:0]      csr_raddr_o,
    input  logic [XLEN-1:0]  csr_rdata_i,
    input  logic             ex_jump_flag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      inst_o,
    output logic [XLEN-1:0]  inst_addr_o,
    output logic [XLEN-1:0]  op1_o,
    output logic [XLEN-1:0]  op2_o,
    output logic [XLEN-1:0]  store_data_o,
    output logic             reg_we_o,
    output logic [RF_AW-1:0] reg_waddr_o,
    output logic             csr_we_o,
    output logic [11:0]      csr_waddr_o,
    output logic [XLEN-1:0]  csr_rdata_o,
    output logic [2:0]       compare_o,
    output logic             illegal_o
);

    localparam int unsigned CSR_AW = 12;
    localparam int unsigned CNT_W  = 2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] OP1_ZERO = 2'd0;
    localparam logic [1:0] OP1_RS1  = 2'd1;
    localparam logic [1:0] OP1_PC   = 2'd2;
    localparam logic [1:0] OP1_IMM  = 2'd3;
    localparam logic [1:0] OP2_ZERO = 2'd0;
    localparam logic [1:0] OP2_RS2  = 2'd1;
    localparam logic [1:0] OP2_IMM  = 2'd2;

    typedef struct packed {
        logic [31:0]       inst;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   store_data;
        logic              reg_we;
        logic [RF_AW-1:0]  reg_waddr;
        logic              csr_we;
        logic [CSR_AW-1:0] csr_waddr;
        logic [XLEN-1:0]   csr_rdata;
        logic [2:0]        compare;
        logic              illegal;
    } out_t;

    logic [6:0]       opcode;
    logic [6:0]       funct7;
    logic [2:0]       funct3;
    logic [RF_AW-1:0] rs1;
    logic [RF_AW-1:0] rs2;
    logic [RF_AW-1:0] rd;
    logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j, zimm;

    logic             use_rs1, use_rs2, dec_we, dec_csr, dec_ill, dec_store, cmp_imm;
    logic [1:0]       op1_sel, op2_sel;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1_data, rs2_data, op1_c, op2_c, cmp_b;
    logic [2:0]       compare_c;

    logic             stall, capture, out_is_load, load_handoff;
    logic             rs1_used, rs2_used, hit_out, hit_cnt;

    out_t             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [RF_AW-1:0] ld_rd_q, ld_rd_d;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign rs1    = RF_AW'(inst_i[19:15]);
    assign rs2    = RF_AW'(inst_i[24:20]);
    assign rd     = RF_AW'(inst_i[11:7]);

    assign imm_i = XLEN'($signed(inst_i[31:20]));
    assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
    assign zimm  = XLEN'(inst_i[19:15]);

    // Opcode/funct decode into source usage, operand selects and write enables
    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        dec_we    = 1'b0;
        dec_csr   = 1'b0;
        dec_ill   = 1'b0;
        dec_store = 1'b0;
        cmp_imm   = 1'b0;
        op1_sel   = OP1_ZERO;
        op2_sel   = OP2_ZERO;
        imm       = '0;
        case (opcode)
            OPC_LUI: begin
                dec_we = 1'b1; op1_sel = OP1_IMM; imm = imm_u;
            end
            OPC_AUIPC: begin
                dec_we = 1'b1; op1_sel = OP1_PC; op2_sel = OP2_IMM; imm = imm_u;
            end
            OPC_JAL: begin
                dec_we = 1'b1; op1_sel = OP1_PC; op2_sel = OP2_IMM; imm = imm_j;
            end
            OPC_JALR: begin
                dec_ill = (funct3 != 3'b000);
                use_rs1 = 1'b1; dec_we = 1'b1;
                op1_sel = OP1_RS1; op2_sel = OP2_IMM; imm = imm_i;
            end
            OPC_BRANCH: begin
                dec_ill = (funct3[2:1] == 2'b01);
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                op1_sel = OP1_PC; op2_sel = OP2_IMM; imm = imm_b;
            end
            OPC_LOAD: begin
                dec_ill = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
                use_rs1 = 1'b1; dec_we = 1'b1;
                op1_sel = OP1_RS1; op2_sel = OP2_IMM; imm = imm_i;
            end
            OPC_STORE: begin
                dec_ill = (funct3 > 3'b010);
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec_store = 1'b1;
                op1_sel = OP1_RS1; op2_sel = OP2_IMM; imm = imm_s;
            end
            OPC_OPIMM: begin
                use_rs1 = 1'b1; dec_we = 1'b1; cmp_imm = 1'b1;
                op1_sel = OP1_RS1; op2_sel = OP2_IMM; imm = imm_i;
                if (funct3 == 3'b001)
                    dec_ill = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    dec_ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec_we = 1'b1;
                op1_sel = OP1_RS1; op2_sel = OP2_RS2;
                if (funct7 == 7'b0100000)
                    dec_ill = (funct3 != 3'b000) && (funct3 != 3'b101);
                else if (funct7 == 7'b0000001) begin
`ifdef ID_RVM_EN
                    dec_ill = 1'b0;
`else
                    dec_ill = 1'b1;
`endif
                end else
                    dec_ill = (funct7 != 7'b0000000);
            end
            OPC_FENCE: begin
                dec_ill = 1'b0;
            end
            OPC_SYSTEM: begin
                // funct3==0 covers ecall/ebreak/mret, which pass through as NOP
                if (funct3 == 3'b100)
                    dec_ill = 1'b1;
                else if (funct3 != 3'b000) begin
                    dec_csr = 1'b1; dec_we = 1'b1;
                    if (funct3[2]) begin
                        op1_sel = OP1_IMM; imm = zimm;
                    end else begin
                        use_rs1 = 1'b1; op1_sel = OP1_RS1;
                    end
                end
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            use_rs1   = 1'b0;
            use_rs2   = 1'b0;
            dec_we    = 1'b0;
            dec_csr   = 1'b0;
            dec_store = 1'b0;
        end
    end

    // Operand muxing and compare flags
    always_comb begin
        rs1_data = use_rs1 ? reg1_rdata_i : '0;
        rs2_data = use_rs2 ? reg2_rdata_i : '0;
        case (op1_sel)
            OP1_RS1: op1_c = rs1_data;
            OP1_PC:  op1_c = inst_addr_i;
            OP1_IMM: op1_c = imm;
            default: op1_c = '0;
        endcase
        case (op2_sel)
            OP2_RS2: op2_c = rs2_data;
            OP2_IMM: op2_c = imm;
            default: op2_c = '0;
        endcase
        cmp_b     = cmp_imm ? imm : rs2_data;
        compare_c = {($signed(rs1_data) >= $signed(cmp_b)), (rs1_data >= cmp_b), (rs1_data == cmp_b)};
    end

    assign reg1_raddr_o = use_rs1 ? rs1 : '0;
    assign reg2_raddr_o = use_rs2 ? rs2 : '0;
    assign csr_raddr_o  = dec_csr ? inst_i[31:20] : '0;

    // Load-use interlock against the load still in ID and the one just handed to EX
    assign rs1_used     = use_rs1 && (rs1 != '0);
    assign rs2_used     = use_rs2 && (rs2 != '0);
    assign out_is_load  = (out_q.inst[6:0] == OPC_LOAD) && !out_q.illegal;
    assign hit_out      = out_valid_q && out_is_load &&
                          ((rs1_used && (rs1 == out_q.reg_waddr)) || (rs2_used && (rs2 == out_q.reg_waddr)));
    assign hit_cnt      = (ld_cnt_q != '0) &&
                          ((rs1_used && (rs1 == ld_rd_q)) || (rs2_used && (rs2 == ld_rd_q)));
    assign stall        = hit_out || hit_cnt;
    assign in_ready_o   = (!out_valid_q || out_ready_i) && !stall;
    assign capture      = in_valid_i && in_ready_o && !ex_jump_flag_i;
    assign load_handoff = out_valid_q && out_ready_i && out_is_load;

    // Next state of the output register and load counter
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        ld_cnt_d    = ld_cnt_q;
        ld_rd_d     = ld_rd_q;
        if (ex_jump_flag_i) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d          = 1'b1;
            out_d.inst           = inst_i;
            out_d.addr           = inst_addr_i;
            out_d.op1            = op1_c;
            out_d.op2            = op2_c;
            out_d.store_data     = dec_store ? rs2_data : '0;
            out_d.reg_we         = dec_we && (rd != '0);
            out_d.reg_waddr      = rd;
            out_d.csr_we         = dec_csr;
            out_d.csr_waddr      = inst_i[31:20];
            out_d.csr_rdata      = dec_csr ? csr_rdata_i : '0;
            out_d.compare        = compare_c;
            out_d.illegal        = dec_ill;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (load_handoff) begin
            ld_cnt_d = CNT_W'(LOAD_LAT);
            ld_rd_d  = out_q.reg_waddr;
        end else if (ld_cnt_q != '0) begin
            ld_cnt_d = ld_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ld_cnt_q    <= '0;
            ld_rd_q     <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ld_cnt_q    <= ld_cnt_d;
            ld_rd_q     <= ld_rd_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign inst_o       = out_q.inst;
    assign inst_addr_o  = out_q.addr;
    assign op1_o        = out_q.op1;
    assign op2_o        = out_q.op2;
    assign store_data_o = out_q.store_data;
    assign reg_we_o     = out_q.reg_we;
    assign reg_waddr_o  = out_q.reg_waddr;
    assign csr_we_o     = out_q.csr_we;
    assign csr_waddr_o  = out_q.csr_waddr;
    assign csr_rdata_o  = out_q.csr_rdata;
    assign compare_o    = out_q.compare;
    assign illegal_o    = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: flow, backpressure, load-use, flush, x0/illegal, compare, CSR, M-ext.
module tb_id_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RF_AW = 5;

    logic             clk;
    logic             rst;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      inst_i;
    logic [XLEN-1:0]  inst_addr_i;
    logic [RF_AW-1:0] reg1_raddr_o, reg2_raddr_o;
    logic [XLEN-1:0]  reg1_rdata_i, reg2_rdata_i;
    logic [11:0]      csr_raddr_o;
    logic [XLEN-1:0]  csr_rdata_i;
    logic             ex_jump_flag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      inst_o;
    logic [XLEN-1:0]  inst_addr_o, op1_o, op2_o, store_data_o;
    logic             reg_we_o;
    logic [RF_AW-1:0] reg_waddr_o;
    logic             csr_we_o;
    logic [11:0]      csr_waddr_o;
    logic [XLEN-1:0]  csr_rdata_o;
    logic [2:0]       compare_o;
    logic             illegal_o;

    int n_checks = 0;
    int n_errors = 0;

    id_stage #(.XLEN(XLEN), .RF_AW(RF_AW), .LOAD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
        .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
        .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
        .ex_jump_flag_i(ex_jump_flag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .op1_o(op1_o), .op2_o(op2_o), .store_data_o(store_data_o),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_rdata_o(csr_rdata_o),
        .compare_o(compare_o), .illegal_o(illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc,
                           input logic [31:0] r1, input logic [31:0] r2);
        in_valid_i   = 1'b1;
        inst_i       = ins;
        inst_addr_i  = pc;
        reg1_rdata_i = r1;
        reg2_rdata_i = r2;
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid_i = 1'b0; inst_i = '0; inst_addr_i = '0;
        reg1_rdata_i = '0; reg2_rdata_i = '0; csr_rdata_i = '0;
        ex_jump_flag_i = 1'b0; out_ready_i = 1'b1;
        tick(); tick();
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_reg_we", 64'(reg_we_o), 64'd0);
        check("rst_op1", 64'(op1_o), 64'd0);
        check("rst_inst", 64'(inst_o), 64'd0);
        check("rst_illegal", 64'(illegal_o), 64'd0);
        rst = 1'b0;

        // flow: addi x1,x0,5 then add x3,x1,x2 back to back
        present(32'h00500093, 32'h100, 32'd0, 32'd0);
        check("flow_ready0", 64'(in_ready_o), 64'd1);
        tick();
        check("flow_valid0", 64'(out_valid_o), 64'd1);
        check("flow_op1", 64'(op1_o), 64'd0);
        check("flow_op2", 64'(op2_o), 64'd5);
        check("flow_we", 64'(reg_we_o), 64'd1);
        check("flow_waddr", 64'(reg_waddr_o), 64'd1);
        check("flow_addr0", 64'(inst_addr_o), 64'h100);
        present(32'h002081B3, 32'h104, 32'd7, 32'd9);
        check("add_raddr1", 64'(reg1_raddr_o), 64'd1);
        check("add_raddr2", 64'(reg2_raddr_o), 64'd2);
        check("flow_ready1", 64'(in_ready_o), 64'd1);
        tick();
        check("add_valid", 64'(out_valid_o), 64'd1);
        check("add_op1", 64'(op1_o), 64'd7);
        check("add_op2", 64'(op2_o), 64'd9);
        check("add_waddr", 64'(reg_waddr_o), 64'd3);
        check("add_addr", 64'(inst_addr_o), 64'h104);

        // backpressure: hold for 3 cycles, then release
        out_ready_i = 1'b0;
        present(32'h00500093, 32'h108, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", 64'(in_ready_o), 64'd0);
            tick();
            check("bp_valid", 64'(out_valid_o), 64'd1);
            check("bp_addr_hold", 64'(inst_addr_o), 64'h104);
            check("bp_op1_hold", 64'(op1_o), 64'd7);
        end
        out_ready_i = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready_o), 64'd1);
        tick();
        check("bp_next_addr", 64'(inst_addr_o), 64'h108);
        check("bp_next_op2", 64'(op2_o), 64'd5);

        // load-use: lw x5,0(x1) then add x6,x5,x2 stalls two cycles
        present(32'h0000A283, 32'h10C, 32'h40, 32'd0);
        check("lw_ready", 64'(in_ready_o), 64'd1);
        tick();
        check("lw_inst", 64'(inst_o), 64'h0000A283);
        check("lw_op1", 64'(op1_o), 64'h40);
        check("lw_op2", 64'(op2_o), 64'd0);
        present(32'h00228333, 32'h110, 32'hDEAD, 32'd1);
        check("lu_stall1", 64'(in_ready_o), 64'd0);
        tick();
        check("lu_valid_gap", 64'(out_valid_o), 64'd0);
        check("lu_stall2", 64'(in_ready_o), 64'd0);
        reg1_rdata_i = 32'h55;
        tick();
        check("lu_release", 64'(in_ready_o), 64'd1);
        check("lu_valid_gap2", 64'(out_valid_o), 64'd0);
        tick();
        check("lu_valid", 64'(out_valid_o), 64'd1);
        check("lu_op1_fresh", 64'(op1_o), 64'h55);
        check("lu_op2", 64'(op2_o), 64'd1);
        check("lu_waddr", 64'(reg_waddr_o), 64'd6);

        // load followed by an independent add x6,x0,x2: no stall
        present(32'h0000A283, 32'h114, 32'h40, 32'd0);
        tick();
        present(32'h00200333, 32'h118, 32'd0, 32'd3);
        check("nolu_ready", 64'(in_ready_o), 64'd1);
        tick();
        check("nolu_addr", 64'(inst_addr_o), 64'h118);
        check("nolu_op2", 64'(op2_o), 64'd3);

        // flush: beq x1,x2,8 presented while EX signals a taken jump
        out_ready_i = 1'b0;
        ex_jump_flag_i = 1'b1;
        present(32'h00208463, 32'h11C, 32'd1, 32'd1);
        tick();
        check("flush_valid", 64'(out_valid_o), 64'd0);
        check("flush_not_captured", 64'(inst_o), 64'h00200333);
        ex_jump_flag_i = 1'b0;
        out_ready_i = 1'b1;

        // beq captured after the flush: op1=pc, op2=imm_b, eq flag
        present(32'h00208463, 32'h11C, 32'd1, 32'd1);
        tick();
        check("beq_op1", 64'(op1_o), 64'h11C);
        check("beq_op2", 64'(op2_o), 64'd8);
        check("beq_cmp", 64'(compare_o), 64'd7);
        check("beq_we", 64'(reg_we_o), 64'd0);

        // x0 write suppression
        present(32'h00100013, 32'h120, 32'd0, 32'd0);
        tick();
        check("x0_valid", 64'(out_valid_o), 64'd1);
        check("x0_we", 64'(reg_we_o), 64'd0);

        // unknown opcode
        present(32'h0000007F, 32'h124, 32'd0, 32'd0);
        tick();
        check("ill_flag", 64'(illegal_o), 64'd1);
        check("ill_we", 64'(reg_we_o), 64'd0);
        check("ill_csr_we", 64'(csr_we_o), 64'd0);

        // slti x7,x1,0 with rs1=-1: signed ge 0, unsigned ge 1, eq 0
        present(32'h0000A393, 32'h128, 32'hFFFF_FFFF, 32'd0);
        tick();
        check("slti_cmp", 64'(compare_o), 64'b010);
        check("slti_op2", 64'(op2_o), 64'd0);
        check("slti_illegal", 64'(illegal_o), 64'd0);

        // csrrw x1,0x300,x2
        csr_rdata_i = 32'hABCD;
        present(32'h300110F3, 32'h12C, 32'h1234, 32'd0);
        check("csr_raddr", 64'(csr_raddr_o), 64'h300);
        tick();
        check("csr_we", 64'(csr_we_o), 64'd1);
        check("csr_waddr", 64'(csr_waddr_o), 64'h300);
        check("csr_rdata", 64'(csr_rdata_o), 64'hABCD);
        check("csr_op1", 64'(op1_o), 64'h1234);
        check("csr_reg_we", 64'(reg_we_o), 64'd1);

        // mul x3,x1,x2
        present(32'h022081B3, 32'h130, 32'd3, 32'd4);
        tick();
`ifdef ID_RVM_EN
        check("mul_we", 64'(reg_we_o), 64'd1);
        check("mul_illegal", 64'(illegal_o), 64'd0);
        check("mul_op2", 64'(op2_o), 64'd4);
`else
        check("mul_we", 64'(reg_we_o), 64'd0);
        check("mul_illegal", 64'(illegal_o), 64'd1);
`endif

        // drain
        in_valid_i = 1'b0;
        tick();
        check("drain_valid", 64'(out_valid_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
